// File: rtl/lut_cfg_loader.sv
// ============================================================================
// Module   : lut_cfg_loader
// Purpose  : Bit-serial configuration loader for one L_FRAG logic fragment.
//            Shifts a frame into a shadow register over a valid/ready
//            handshake, optionally checks even parity, and commits the whole
//            truth table to fragBitInfo in a single cycle so the LUT never
//            sees a partial table.
// Options  : `define LUT_CFG_PARITY_EN adds a trailing even-parity bit, the
//            PARITY state and the sticky cfg_err flag. Without it the frame
//            is CFG_WIDTH bits, every frame commits and cfg_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lut_cfg_loader #(
    parameter int                   CFG_WIDTH = 16,
    parameter logic [CFG_WIDTH-1:0] RESET_CFG = {CFG_WIDTH{1'b0}}
) (
    input  logic                 QCK,
    input  logic                 QRT,
    input  logic                 cfg_start,
    input  logic                 cfg_din,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    output logic [CFG_WIDTH-1:0] fragBitInfo,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_err
);

    localparam int C_CNT_W = $clog2(CFG_WIDTH + 1);
    localparam int C_IDX_W = $clog2(CFG_WIDTH);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(CFG_WIDTH - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_COMMIT = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [CFG_WIDTH-1:0] r_shadow;
    logic [CFG_WIDTH-1:0] r_frag;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_done;
    logic                 w_xfer;
    logic                 w_start_ok;
    logic                 w_commit_ok;

    // A bit moves only when the loader is ready and the source is valid.
    assign w_xfer     = cfg_valid && cfg_ready;
    assign w_start_ok = (r_state == S_IDLE) && cfg_start;

    // State register.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; the last data bit goes to PARITY or straight to COMMIT.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_xfer && (r_cnt == C_CNT_LAST)) begin
`ifdef LUT_CFG_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_COMMIT;
`endif
                end
            end
`ifdef LUT_CFG_PARITY_EN
            S_PARITY: begin
                if (w_xfer) begin
                    w_state_nxt = S_COMMIT;
                end
            end
`endif
            S_COMMIT: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        cfg_ready = (r_state == S_SHIFT) || (r_state == S_PARITY);
        cfg_busy  = (r_state != S_IDLE);
    end

    // Shadow register and bit counter; data bit 0 arrives first.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_shadow <= {CFG_WIDTH{1'b0}};
            r_cnt    <= {C_CNT_W{1'b0}};
        end else if (w_start_ok) begin
            r_cnt <= {C_CNT_W{1'b0}};
        end else if ((r_state == S_SHIFT) && w_xfer) begin
            r_shadow[r_cnt[C_IDX_W-1:0]] <= cfg_din;
            r_cnt                        <= r_cnt + C_CNT_W'(1);
        end
    end

`ifdef LUT_CFG_PARITY_EN
    logic r_par_ok;
    logic r_err;

    // Even parity over the data bits plus the trailing parity bit.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_par_ok <= 1'b0;
        end else if ((r_state == S_PARITY) && w_xfer) begin
            r_par_ok <= ~((^r_shadow) ^ cfg_din);
        end
    end

    // Sticky error: cleared by an accepted start, set by a failed commit.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_err <= 1'b0;
        end else if (w_start_ok) begin
            r_err <= 1'b0;
        end else if ((r_state == S_COMMIT) && !r_par_ok) begin
            r_err <= 1'b1;
        end
    end

    assign w_commit_ok = r_par_ok;
    assign cfg_err     = r_err;
`else
    assign w_commit_ok = 1'b1;
    assign cfg_err     = 1'b0;
`endif

    // Atomic commit of the shadow table, with a one-cycle done pulse after it.
    always_ff @(posedge QCK or posedge QRT) begin
        if (QRT) begin
            r_frag <= RESET_CFG;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_COMMIT) && w_commit_ok;
            if ((r_state == S_COMMIT) && w_commit_ok) begin
                r_frag <= r_shadow;
            end
        end
    end

    assign fragBitInfo = r_frag;
    assign cfg_done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_lut_cfg_loader.sv
// ============================================================================
// Module   : tb_lut_cfg_loader
// Purpose  : Self-checking bench for lut_cfg_loader. Directed frames from the
//            test plan followed by random frames with random valid gaps,
//            checked against a frame-level model (committed table, sticky
//            error, handshake cycle counts, commit timing).
// Options  : honours `define LUT_CFG_PARITY_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lut_cfg_loader;

`ifdef LUT_CFG_PARITY_EN
    localparam int C_FLEN   = 17;
    localparam bit C_PAR_EN = 1'b1;
`else
    localparam int C_FLEN   = 16;
    localparam bit C_PAR_EN = 1'b0;
`endif

    logic        QCK;
    logic        QRT;
    logic        cfg_start;
    logic        cfg_din;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] fragBitInfo;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;

    int n_vec;
    int n_bad;

    // Frame-level reference state.
    logic [15:0] m_frag;
    logic        m_err;

    lut_cfg_loader #(
        .CFG_WIDTH (16),
        .RESET_CFG (16'h0000)
    ) u_dut (
        .QCK         (QCK),
        .QRT         (QRT),
        .cfg_start   (cfg_start),
        .cfg_din     (cfg_din),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .fragBitInfo (fragBitInfo),
        .cfg_busy    (cfg_busy),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err)
    );

    initial QCK = 1'b0;
    always #5 QCK = ~QCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame. gap_mode: 0 valid held, 1 pattern 1,0,0 repeating,
    // 2 random. start_mid re-pulses cfg_start after 5 accepted bits.
    task automatic run_frame(input logic [15:0] data, input logic par,
                             input int gap_mode, input bit start_mid);
        logic [16:0] bits;
        logic        good;
        logic        v;
        int          idx;
        int          cyc;
        int          ready_cnt;
        int          stable_bad;
        int          busy_bad;
        int          done_bad;

        bits       = {par, data};
        good       = !C_PAR_EN || ((($countones(data) + int'(par)) % 2) == 0);
        idx        = 0;
        cyc        = 0;
        ready_cnt  = 0;
        stable_bad = 0;
        busy_bad   = 0;
        done_bad   = 0;

        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        cfg_din   = 1'($urandom);
        @(posedge QCK);
        #1;
        cfg_start = 1'b0;
        chk("err_clr_on_start", 32'(cfg_err), 32'd0);

        while ((idx < C_FLEN) && (cyc < 400)) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = ((cyc % 3) == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            cfg_valid = v;
            cfg_din   = v ? bits[idx] : 1'($urandom);
            cfg_start = start_mid && (idx == 5);
            if (cfg_ready) ready_cnt++;
            if (!cfg_busy) busy_bad++;
            if (cfg_done) done_bad++;
            @(posedge QCK);
            if (v && cfg_ready) idx++;
            #1;
            cfg_start = 1'b0;
            if (fragBitInfo !== m_frag) stable_bad++;
            cyc++;
        end
        cfg_valid = 1'b0;
        if (idx < C_FLEN) chk("frame_timeout", 32'd1, 32'd0);

        chk("ready_cycles", 32'(ready_cnt), 32'(cyc));
        chk("frag_stable_in_frame", 32'(stable_bad), 32'd0);
        chk("busy_in_frame", 32'(busy_bad), 32'd0);
        chk("done_in_frame", 32'(done_bad), 32'd0);
        // COMMIT cycle: handshake closed, table not yet updated.
        chk("ready_in_commit", 32'(cfg_ready), 32'd0);
        chk("frag_before_commit", 32'(fragBitInfo), 32'(m_frag));

        @(posedge QCK);
        #1;
        if (good) m_frag = data;
        m_err = !good;
        chk("frag_after_commit", 32'(fragBitInfo), 32'(m_frag));
        chk("done_pulse", 32'(cfg_done), 32'(good));
        chk("err_after_commit", 32'(cfg_err), 32'(m_err));
        chk("busy_after_commit", 32'(cfg_busy), 32'd0);

        @(posedge QCK);
        #1;
        chk("done_one_cycle", 32'(cfg_done), 32'd0);
        chk("frag_hold", 32'(fragBitInfo), 32'(m_frag));
        chk("err_hold", 32'(cfg_err), 32'(m_err));
    endtask

    // Starts a frame, pushes nbits bits, then asserts QRT between edges.
    task automatic reset_mid_frame(input logic [15:0] data, input int nbits);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(posedge QCK);
        #1;
        cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_din   = data[i];
            @(posedge QCK);
            #1;
        end
        cfg_valid = 1'b0;
        #2;
        QRT = 1'b1;
        #1;
        m_frag = 16'h0000;
        m_err  = 1'b0;
        chk("rst_mid_frag", 32'(fragBitInfo), 32'h0000);
        chk("rst_mid_busy", 32'(cfg_busy), 32'd0);
        chk("rst_mid_ready", 32'(cfg_ready), 32'd0);
        chk("rst_mid_err", 32'(cfg_err), 32'd0);
        @(posedge QCK);
        #1;
        QRT = 1'b0;
        @(posedge QCK);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        m_frag    = 16'h0000;
        m_err     = 1'b0;
        QRT       = 1'b1;
        cfg_start = 1'b0;
        cfg_din   = 1'b0;
        cfg_valid = 1'b0;

        repeat (3) @(posedge QCK);
        #1;
        chk("reset_frag", 32'(fragBitInfo), 32'h0000);
        chk("reset_ready", 32'(cfg_ready), 32'd0);
        chk("reset_busy", 32'(cfg_busy), 32'd0);
        chk("reset_done", 32'(cfg_done), 32'd0);
        chk("reset_err", 32'(cfg_err), 32'd0);
        QRT = 1'b0;
        @(posedge QCK);
        #1;

        run_frame(16'h8000, 1'b1, 0, 1'b0);
        run_frame(16'h6996, 1'b1, 0, 1'b0);
        run_frame(16'hFFFE, 1'b1, 1, 1'b0);
        run_frame(16'h0F0F, 1'b0, 0, 1'b1);
        run_frame(16'h8000, 1'b1, 0, 1'b0);
        reset_mid_frame(16'h1234, 9);
        run_frame(16'h1234, 1'b1, 0, 1'b0);
        run_frame(16'hA5A5, 1'b0, 0, 1'b0);

        for (int k = 0; k < 25; k++) begin
            run_frame(16'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                      1'($urandom_range(0, 3) == 0));
            repeat (int'($urandom_range(0, 3))) @(posedge QCK);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/lut_cfg_loader.md
Name: lut_cfg_loader

Overview:
- Serial configuration loader for one L_FRAG logic fragment.
- Sits directly upstream of the LUT and drives its 16-bit fragBitInfo truth-table input.
- Accepts a bit-serial frame on a valid/ready handshake into a shadow register, checks it, and commits it atomically, so the LUT never sees a partial table.

Parameters:
- CFG_WIDTH, 16, number of truth-table bits per frame. Must be 16 for L_FRAG; the counter is sized $clog2(CFG_WIDTH+1).
- RESET_CFG, 16'h0000, value driven on fragBitInfo after reset.

Ports:
- QCK  input  1  clock; all state updates on the rising edge.
- QRT  input  1  reset, asynchronous, active-high.
- cfg_start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- cfg_din  input  1  serial data bit. Truth-table bit 0 is sent first.
- cfg_valid  input  1  cfg_din is valid this cycle.
- cfg_ready  output  1  loader accepts a bit this cycle.
- fragBitInfo  output  CFG_WIDTH  committed LUT truth table.
- cfg_busy  output  1  high in any state other than IDLE.
- cfg_done  output  1  one-cycle pulse on a successful commit.
- cfg_err  output  1  sticky parity error; cleared by the next accepted cfg_start.

Behaviour:
- Reset is asynchronous, active-high on QRT. On reset:
  - fragBitInfo=RESET_CFG, shadow=0, cnt=0, state=IDLE.
  - cfg_ready=0, cfg_busy=0, cfg_done=0, cfg_err=0.
- A bit transfers on a rising edge where cfg_valid && cfg_ready. cfg_din is ignored when no transfer occurs.
- States:
  - IDLE: cfg_ready=0. If cfg_start=1: next state SHIFT, cnt<=0, cfg_err<=0.
  - SHIFT: cfg_ready=1. On each transfer, shadow[cnt]<=cfg_din and cnt<=cnt+1. The transfer with cnt==CFG_WIDTH-1 moves to PARITY, or to COMMIT when parity is compiled out.
  - PARITY: cfg_ready=1. One transfer captures the parity bit p. Next state COMMIT; par_ok<=(^shadow ^ p)==0 (even parity over data plus p).
  - COMMIT: cfg_ready=0, lasts one cycle.
    - If par_ok: fragBitInfo<=shadow and cfg_done=1 for the cycle after this edge.
    - Else: cfg_err<=1 and fragBitInfo is unchanged.
    - Next state IDLE.
- Latency: with cfg_valid held high, fragBitInfo changes at the 2nd edge after the last (parity) bit is accepted. That is CFG_WIDTH+3 edges after cfg_start is sampled, including the IDLE->SHIFT edge.
- fragBitInfo changes only in COMMIT. It is stable throughout SHIFT and PARITY, so the LUT keeps its old function during a reload.
- cfg_start outside IDLE is ignored and does not restart the frame.
- cfg_valid gaps of any length stall the frame indefinitely. There is no timeout.
- QRT asserted mid-frame:
  - Discards shadow and cnt.
  - fragBitInfo returns to RESET_CFG, not the previously committed value.
- cfg_done and cfg_err are never high in the same cycle. cfg_done is combinationally 0 outside the post-commit cycle.

Optional Feature:
- Macro LUT_CFG_PARITY_EN.
- Defined: PARITY state present, frame is CFG_WIDTH+1 bits, cfg_err operates as above.
- Undefined:
  - No PARITY state; the frame is CFG_WIDTH bits.
  - SHIFT goes straight to COMMIT, which always commits.
  - cfg_err is tied to 0 and its register is removed.

Test Plan:
- Defined build, reset then frame 16'h8000 + p=1 with cfg_valid held high:
  - cfg_ready is high for 17 cycles.
  - fragBitInfo=16'h8000 two edges after the parity bit.
  - cfg_done high exactly one cycle; cfg_err=0.
- Frame 16'h6996 with p=1 (popcount 8, bad parity):
  - cfg_err=1, cfg_done never high, fragBitInfo keeps its prior value 16'h8000.
  - Next cfg_start clears cfg_err to 0.
- Frame 16'hFFFE, p=1, with cfg_valid toggling 1,0,0,1,...:
  - Only valid cycles are shifted.
  - Final fragBitInfo=16'hFFFE; fragBitInfo is unchanged until COMMIT.
- cfg_start pulsed mid-SHIFT after 5 bits: ignored, cnt continues, the frame completes normally.
- QRT asserted after 9 bits of frame 16'h1234, with fragBitInfo=16'h8000 committed beforehand:
  - Immediately fragBitInfo=16'h0000, state IDLE, cfg_busy=0.
  - A following full frame 16'h1234 (p=1) commits correctly.
- Build without the macro, frame 16'hA5A5 (16 bits):
  - Commit at the 2nd edge after the 16th bit.
  - cfg_ready is high for exactly 16 cycles; cfg_err stays 0.
